id_operand_stage: RTL

- Decode-side operand stage that sits directly upstream of the register file and feeds EX.
- Holds the IF/ID pipeline register and drives the register-file read addresses from the held instruction.
- Resolves both source operands from EX/MEM/WB bypass or from the register-file read data, and detects load-use hazards.
- Registers the result into the ID/EX output register under a valid/ready handshake.

---
 rtl/id_operand_stage_pkg.sv | 36 +++
 rtl/id_operand_stage_bypass_mux.sv | 39 +++
 rtl/id_operand_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode operand stage: widths, opcodes, instruction
// field positions and the source-use decode helpers.
package id_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  // Jumps and LUI carry no register in the rs field.
  function automatic logic uses_rs(input logic [5:0] op);
    return !(op == OP_J || op == OP_JAL || op == OP_LUI);
  endfunction

  // Only R-type, branches and stores read rt as a source.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_operand_stage_bypass_mux.sv
// Resolves one source operand: EX > MEM > WB bypass, else register-file data.
// Register 0 always resolves to zero.
module id_operand_stage_bypass_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] rdata,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] operand
);

  logic src_nz;
  assign src_nz = (src_addr != '0);

  // WB hit is needed because the register file has no write-through path.
  always_comb begin
    operand = rdata;
    if (!src_nz)
      operand = '0;
    else if (ex_we && ex_waddr == src_addr)
      operand = ex_wdata;
    else if (mem_we && mem_waddr == src_addr)
      operand = mem_wdata;
    else if (wb_we && wb_waddr == src_addr)
      operand = wb_wdata;
  end

endmodule

// File: rtl/id_operand_stage.sv
// IF/ID holding register, operand resolution with bypass and load-use stall,
// and the ID/EX output register under a valid/ready handshake.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [DW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  input  logic          flush,
  output logic [AW-1:0] raddr1,
  output logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          id_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  output logic [DW-1:0] id_src1,
  output logic [DW-1:0] id_src2
);

  logic          a_valid_reg;
  logic [DW-1:0] a_pc_reg;
  logic [DW-1:0] a_inst_reg;

  logic          id_valid_reg;
  logic [DW-1:0] id_pc_reg;
  logic [DW-1:0] id_inst_reg;
  logic [DW-1:0] id_src1_reg;
  logic [DW-1:0] id_src2_reg;

  logic [5:0]    opcode;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic          use_rs;
  logic          use_rt;
  logic          load_use;
  logic          out_free;
  logic          advance;

  logic [AW-1:0] src_addr  [2];
  logic [DW-1:0] src_rdata [2];
  logic [DW-1:0] src_val   [2];

  assign opcode = a_inst_reg[OPC_HI:OPC_LO];
  assign rs     = a_inst_reg[RS_HI:RS_LO];
  assign rt     = a_inst_reg[RT_HI:RT_LO];
  assign use_rs = uses_rs(opcode);
  assign use_rt = uses_rt(opcode);

  // Read addresses follow the held instruction regardless of a_valid.
  assign raddr1 = rs;
  assign raddr2 = rt;

  assign src_addr[0]  = rs;
  assign src_addr[1]  = rt;
  assign src_rdata[0] = rdata1;
  assign src_rdata[1] = rdata2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      id_operand_stage_bypass_mux #(
        .DW(DW),
        .AW(AW)
      ) u_bypass_mux (
        .src_addr  (src_addr[gi]),
        .rdata     (src_rdata[gi]),
        .ex_we     (ex_we),
        .ex_waddr  (ex_waddr),
        .ex_wdata  (ex_wdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .operand   (src_val[gi])
      );
    end
  endgenerate

  // A load in EX cannot forward its data until it reaches MEM.
  assign load_use = a_valid_reg && ex_we && ex_is_load && (ex_waddr != '0) &&
                    ((use_rs && ex_waddr == rs) || (use_rt && ex_waddr == rt));

  assign out_free = !id_valid_reg || ex_ready;
  assign advance  = a_valid_reg && !load_use && out_free;
  assign if_ready = (!a_valid_reg || advance) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_reg <= 1'b0;
      a_pc_reg    <= '0;
      a_inst_reg  <= '0;
    end else if (flush) begin
      a_valid_reg <= 1'b0;
    end else if (if_valid && if_ready) begin
      a_valid_reg <= 1'b1;
      a_pc_reg    <= if_pc;
      a_inst_reg  <= if_inst;
    end else if (advance) begin
      a_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
      id_src1_reg  <= '0;
      id_src2_reg  <= '0;
    end else if (advance && !flush) begin
      id_valid_reg <= 1'b1;
      id_pc_reg    <= a_pc_reg;
      id_inst_reg  <= a_inst_reg;
      id_src1_reg  <= src_val[0];
      id_src2_reg  <= src_val[1];
    end else if (out_free) begin
      id_valid_reg <= 1'b0;
    end
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;
  assign id_src1  = id_src1_reg;
  assign id_src2  = id_src2_reg;

endmodule
